// File: rtl/cas_pkg.sv
// Shared types and constants for the MC-10 cassette FSK encoder.
package cas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cas_state_e;

  // Half-cycle lengths at the 0.89 MHz core clock: 2400 Hz ('1') and 1200 Hz ('0').
  localparam int HALF_1_DEF = 185;
  localparam int HALF_0_DEF = 371;

  localparam logic [7:0] AUD_HI  = 8'hC0;
  localparam logic [7:0] AUD_LO  = 8'h40;
  localparam logic [7:0] AUD_MID = 8'h80;

endpackage

// File: rtl/cas_half_timer.sv
// Loadable half-period down-counter; holds at zero and flags it.
module cas_half_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cas_fsk_encoder.sv
// Serialises one byte (LSB first) into one FSK square cycle per bit.
// Optional feature macro CAS_FSK_AUDIO_EN adds the 8-bit audio mix output.
module cas_fsk_encoder
  import cas_pkg::*;
#(
  parameter int HALF_1 = HALF_1_DEF,
  parameter int HALF_0 = HALF_0_DEF,
  parameter int CNT_W  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] din,
  output logic       done,
  output logic       dout,
  output logic       busy
`ifdef CAS_FSK_AUDIO_EN
  ,
  output logic [7:0] audio
`endif
);

  localparam logic [CNT_W-1:0] RELOAD_1 = CNT_W'(HALF_1 - 1);
  localparam logic [CNT_W-1:0] RELOAD_0 = CNT_W'(HALF_0 - 1);

  cas_state_e       state_q;
  logic             dout_q;
  logic             done_q;
  logic             busy_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  cas_half_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Reload value is chosen by the bit that the *next* half-cycle belongs to.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = RELOAD_0;
    case (state_q)
      IDLE: begin
        cnt_load = start;
        cnt_val  = din[0] ? RELOAD_1 : RELOAD_0;
      end
      HIGH: begin
        cnt_load = cnt_zero;
        cnt_val  = shift_q[0] ? RELOAD_1 : RELOAD_0;
      end
      LOW: begin
        cnt_load = cnt_zero && (bit_idx_q != 3'd7);
        cnt_val  = shift_q[1] ? RELOAD_1 : RELOAD_0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dout_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dout_q <= 1'b0;
          if (start) begin
            shift_q   <= din;
            bit_idx_q <= '0;
            state_q   <= HIGH;
            dout_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_zero) begin
            state_q <= LOW;
            dout_q  <= 1'b0;
          end
        end
        LOW: begin
          if (cnt_zero) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              state_q   <= HIGH;
              dout_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAS_FSK_AUDIO_EN
  logic [7:0] audio_q;

  // Mirrors the FSM transitions so the level changes on the same edge as dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_q <= AUD_MID;
    end else begin
      case (state_q)
        IDLE: audio_q <= start ? AUD_HI : AUD_MID;
        HIGH: if (cnt_zero) audio_q <= AUD_LO;
        LOW: begin
          if (cnt_zero) audio_q <= (bit_idx_q == 3'd7) ? AUD_MID : AUD_HI;
        end
        default: audio_q <= AUD_MID;
      endcase
    end
  end

  assign audio = audio_q;
`endif

  assign dout = dout_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_cas_fsk_encoder.sv
// Randomised bench for cas_fsk_encoder against a per-cycle waveform model.
module tb_cas_fsk_encoder;

  localparam int H1 = 185;
  localparam int H0 = 371;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] din;
  wire        done;
  wire        dout;
  wire        busy;
`ifdef CAS_FSK_AUDIO_EN
  wire  [7:0] audio;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;
  bit exp_q[$];

  cas_fsk_encoder dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (din),
    .done  (done),
    .dout  (dout),
    .busy  (busy)
`ifdef CAS_FSK_AUDIO_EN
    ,
    .audio (audio)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected dout for cycles 1..N after start: per bit, HALF highs then HALF lows.
  function automatic void build_wave(input logic [7:0] b);
    int h;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      h = b[i] ? H1 : H0;
      repeat (h) exp_q.push_back(1'b1);
      repeat (h) exp_q.push_back(1'b0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
`ifdef CAS_FSK_AUDIO_EN
      if (audio !== 8'h80) bad++;
`endif
      tick();
    end
    check("idle", 32'(bad), 32'd0);
  endtask

  // pre: start/din were already driven in the previous done cycle.
  task automatic send(input logic [7:0] b, input bit pre, input int disturb_at,
                      input bit chain, input logic [7:0] nb);
    int dur, wave_err, busy_err, early_done, aud_err;
    build_wave(b);
    dur = exp_q.size();
    wave_err = 0; busy_err = 0; early_done = 0; aud_err = 0;
    if (!pre) begin
      start = 1'b1;
      din   = b;
    end
    tick();
    start = 1'b0;
    din   = 8'($urandom);
    for (int k = 1; k <= dur; k++) begin
      if (dout !== exp_q[k-1]) wave_err++;
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) early_done++;
`ifdef CAS_FSK_AUDIO_EN
      if (audio !== (exp_q[k-1] ? 8'hC0 : 8'h40)) aud_err++;
`endif
      if (k == disturb_at) begin
        start = 1'b1;
        din   = ~b;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("wave", 32'(wave_err), 32'd0);
    check("busy_run", 32'(busy_err), 32'd0);
    check("done_early", 32'(early_done), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("dout_at_done", 32'(dout), 32'd0);
`ifdef CAS_FSK_AUDIO_EN
    check("audio_run", 32'(aud_err), 32'd0);
    check("audio_at_done", 32'(audio), 32'h80);
`endif
    $display("tx byte=%02h dur=%0d disturb=%0d chained_in=%0d chain_out=%0d errors=%0d",
             b, dur, disturb_at, pre, chain, err_cnt);
    if (chain) begin
      start = 1'b1;
      din   = nb;
    end else begin
      tick();
      check("done_single", 32'(done), 32'd0);
    end
  endtask

  task automatic reset_mid(input logic [7:0] b);
    int t, h4, seen;
    t = 0;
    for (int i = 0; i < 4; i++) t += 2 * (b[i] ? H1 : H0);
    h4 = b[4] ? H1 : H0;
    t += h4 + h4 / 2;
    start = 1'b1;
    din   = b;
    tick();
    start = 1'b0;
    repeat (t - 1) tick();
    check("pre_reset_low", 32'(dout), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef CAS_FSK_AUDIO_EN
    check("rst_audio", 32'(audio), 32'h80);
`endif
    seen = 0;
    for (int i = 0; i < 6000; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || dout !== 1'b0) seen++;
      tick();
    end
    check("no_done_after_rst", 32'(seen), 32'd0);
    $display("tx reset_mid byte=%02h at_cycle=%0d errors=%0d", b, t, err_cnt);
  endtask

  initial begin
    logic [7:0] r1, r2;
    reset = 1'b1;
    start = 1'b0;
    din   = 8'h00;
    repeat (3) tick();
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
`ifdef CAS_FSK_AUDIO_EN
    check("reset_audio", 32'(audio), 32'h80);
`endif
    reset = 1'b0;
    idle(5);

    send(8'hFF, 1'b0, 0, 1'b0, 8'h00);
    idle(3);
    send(8'h00, 1'b0, 0, 1'b0, 8'h00);
    idle(3);
    send(8'hA5, 1'b0, 0, 1'b0, 8'h00);
    idle(2);
    send(8'($urandom), 1'b0, 100, 1'b0, 8'h00);
    idle(4);

    r1 = 8'($urandom);
    r2 = 8'($urandom);
    send(r1, 1'b0, 0, 1'b1, r2);
    send(r2, 1'b1, 0, 1'b0, 8'h00);
    idle(2);

    reset_mid(8'($urandom));

    reset = 1'b1;
    start = 1'b1;
    din   = 8'hFF;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_dout", 32'(dout), 32'd0);
    idle(3);
    $display("tx reset_with_start errors=%0d", err_cnt);

    for (int i = 0; i < 2; i++) begin
      send(8'($urandom), 1'b0, 0, 1'b0, 8'h00);
      idle(int'($urandom_range(1, 6)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
